// File: rtl/addsub_result_stage.sv
// Result buffer that sits after the 32-bit add/sub stage.
// It keeps add/sub results in a small FIFO with a valid/ready handshake on both
// sides. It also derives zero/negative flags for the head entry, keeps a sticky
// overflow flag, and counts accepted results with a saturating counter.
module addsub_result_stage #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_ans,
    input  logic                     in_cout,
    input  logic                     in_v,
    input  logic                     clr_sticky,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_ans,
    output logic                     out_cout,
    output logic                     out_v,
    output logic                     out_zero,
    output logic                     out_neg,
    output logic                     sticky_v,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    // Pointers wrap naturally because DEPTH is a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return p + 1'b1;
    endfunction

    // The accepted-result counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (&c) begin
            return c;
        end
        return c + 1'b1;
    endfunction

    // Entry storage. It is not reset: the level and pointers decide what is live.
    logic [31:0]      ans_mem_q  [DEPTH];
    logic             cout_mem_q [DEPTH];
    logic             v_mem_q    [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q,  level_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             sticky_q, sticky_d;

    logic             push;
    logic             pop;
    logic             not_empty;
    logic [31:0]      head_ans;
    logic             head_cout;
    logic             head_v;

    // Full and empty come from the level counter. Pointer equality is ambiguous here.
    assign not_empty = (level_q != '0);
    assign in_ready  = (level_q != FULL_LVL);
    assign out_valid = not_empty;

    // A push needs room now, so a full buffer refuses input even while it is popping.
    assign push = in_valid && in_ready;
    assign pop  = out_ready && not_empty;

    assign head_ans  = ans_mem_q[rd_ptr_q];
    assign head_cout = cout_mem_q[rd_ptr_q];
    assign head_v    = v_mem_q[rd_ptr_q];

    // Head outputs are forced to zero while the buffer is empty, so stale entries never show.
    always_comb begin
        out_ans  = '0;
        out_cout = 1'b0;
        out_v    = 1'b0;
        out_zero = 1'b0;
        out_neg  = 1'b0;
        if (not_empty) begin
            out_ans  = head_ans;
            out_cout = head_cout;
            out_v    = head_v;
            out_zero = (head_ans == 32'h0);
            out_neg  = head_ans[31];
        end
    end

    assign level    = level_q;
    assign count    = count_q;
    assign sticky_v = sticky_q;

    // Next-state logic for the pointers, level, counter and sticky flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        count_d  = count_q;
        sticky_d = sticky_q;

        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
            count_d  = sat_inc(count_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        // If an overflowing push and a clear arrive together, the push wins.
        if (push && in_v) begin
            sticky_d = 1'b1;
        end else if (clr_sticky) begin
            sticky_d = 1'b0;
        end
    end

    // Control registers. Reset takes priority over any push, pop or clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            count_q  <= '0;
            sticky_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            count_q  <= count_d;
            sticky_q <= sticky_d;
        end
    end

    // Entry write port. It is gated only by an accepted push, so idle input data is never stored.
    always_ff @(posedge clk) begin
        if (push) begin
            ans_mem_q[wr_ptr_q]  <= in_ans;
            cout_mem_q[wr_ptr_q] <= in_cout;
            v_mem_q[wr_ptr_q]    <= in_v;
        end
    end

endmodule

// File: tb/tb_addsub_result_stage.sv
// Bench for addsub_result_stage: a hand-computed vector table, directed corner
// sequences, and random traffic checked against a queue-based reference model.
module tb_addsub_result_stage;

    localparam int DEPTH = 4;
    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_cout, in_v, clr_sticky, out_ready;
    logic [31:0] in_ans;

    logic        in_ready, out_valid, out_cout, out_v, out_zero, out_neg, sticky_v;
    logic [31:0] out_ans;
    logic [2:0]  level;
    logic [15:0] count;

    logic        s_in_ready, s_out_valid, s_out_cout, s_out_v, s_out_zero, s_out_neg, s_sticky_v;
    logic [31:0] s_out_ans;
    logic [2:0]  s_level;
    logic [3:0]  s_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    addsub_result_stage #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_ans(in_ans), .in_cout(in_cout), .in_v(in_v), .clr_sticky(clr_sticky),
        .out_valid(out_valid), .out_ready(out_ready), .out_ans(out_ans),
        .out_cout(out_cout), .out_v(out_v), .out_zero(out_zero), .out_neg(out_neg),
        .sticky_v(sticky_v), .level(level), .count(count)
    );

    addsub_result_stage #(.DEPTH(DEPTH), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_ans(in_ans), .in_cout(in_cout), .in_v(in_v), .clr_sticky(clr_sticky),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_ans(s_out_ans),
        .out_cout(s_out_cout), .out_v(s_out_v), .out_zero(s_out_zero), .out_neg(s_out_neg),
        .sticky_v(s_sticky_v), .level(s_level), .count(s_count)
    );

    // Reference model: a queue of entries plus plain integer counters.
    typedef struct packed {
        logic [31:0] ans;
        logic        cout;
        logic        v;
    } ent_t;

    ent_t        mq[$];
    int unsigned mcount  = 0;
    bit          msticky = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit vld, input logic [31:0] a, input bit c,
                              input bit v, input bit ordy, input bit clr);
        int n;
        bit pu, po;
        n  = mq.size();
        pu = vld && (n < DEPTH);
        po = ordy && (n > 0);
        if (r) begin
            mq.delete();
            mcount  = 0;
            msticky = 1'b0;
        end else begin
            if (po) void'(mq.pop_front());
            if (pu) begin
                mq.push_back('{ans: a, cout: c, v: v});
                if (mcount < 65535) mcount++;
            end
            if (pu && v) msticky = 1'b1;
            else if (clr) msticky = 1'b0;
        end
    endtask

    task automatic check_model();
        int          n;
        logic [31:0] ha;
        logic        hc, hv;
        int unsigned sc;
        n  = mq.size();
        ha = (n > 0) ? mq[0].ans : 32'h0;
        hc = (n > 0) ? mq[0].cout : 1'b0;
        hv = (n > 0) ? mq[0].v : 1'b0;
        sc = (mcount > 15) ? 15 : mcount;
        chk("in_ready",  32'(in_ready),  32'(n != DEPTH));
        chk("out_valid", 32'(out_valid), 32'(n != 0));
        chk("out_ans",   out_ans,        ha);
        chk("out_cout",  32'(out_cout),  32'(hc));
        chk("out_v",     32'(out_v),     32'(hv));
        chk("out_zero",  32'(out_zero),  32'((n > 0) && (ha == 32'h0)));
        chk("out_neg",   32'(out_neg),   32'((n > 0) && ha[31]));
        chk("level",     32'(level),     32'(n));
        chk("count",     32'(count),     mcount);
        chk("sticky_v",  32'(sticky_v),  32'(msticky));
        chk("small_count", 32'(s_count), sc);
    endtask

    // Drive one cycle of inputs, clock it, update the model, then check at the falling edge.
    task automatic cycle(input bit r, input bit vld, input logic [31:0] a, input bit c,
                         input bit v, input bit ordy, input bit clr);
        rst        = r;
        in_valid   = vld;
        in_ans     = a;
        in_cout    = c;
        in_v       = v;
        out_ready  = ordy;
        clr_sticky = clr;
        @(posedge clk);
        model_step(r, vld, a, c, v, ordy, clr);
        @(negedge clk);
        check_model();
    endtask

    typedef struct {
        bit          rst, vld;
        logic [31:0] ans;
        bit          cout, v, ordy, clr;
        bit          e_valid;
        logic [31:0] e_ans;
        bit          e_cout, e_v, e_zero, e_neg;
        logic [2:0]  e_level;
        logic [15:0] e_count;
        bit          e_rdy, e_sticky;
    } row_t;

    row_t tbl[17];

    initial begin
        //          rst vld ans            c  v  ordy clr | valid ans            c  v  z  n  lvl   cnt     rdy sticky
        tbl[0]  = '{H, L, 32'h0,         L, L, L, L,   L, 32'h0,         L, L, L, L, 3'd0, 16'd0, H, L};
        tbl[1]  = '{L, H, 32'h5,         L, L, L, L,   H, 32'h5,         L, L, L, L, 3'd1, 16'd1, H, L};
        tbl[2]  = '{L, L, 32'h0,         L, L, H, L,   L, 32'h0,         L, L, L, L, 3'd0, 16'd1, H, L};
        tbl[3]  = '{L, H, 32'h1,         L, L, L, L,   H, 32'h1,         L, L, L, L, 3'd1, 16'd2, H, L};
        tbl[4]  = '{L, H, 32'h2,         L, L, L, L,   H, 32'h1,         L, L, L, L, 3'd2, 16'd3, H, L};
        tbl[5]  = '{L, H, 32'h3,         L, L, L, L,   H, 32'h1,         L, L, L, L, 3'd3, 16'd4, H, L};
        tbl[6]  = '{L, H, 32'h4,         L, L, L, L,   H, 32'h1,         L, L, L, L, 3'd4, 16'd5, L, L};
        tbl[7]  = '{L, H, 32'h9,         L, H, L, L,   H, 32'h1,         L, L, L, L, 3'd4, 16'd5, L, L};
        tbl[8]  = '{L, L, 32'hDEAD_BEEF, H, H, H, L,   H, 32'h2,         L, L, L, L, 3'd3, 16'd5, H, L};
        tbl[9]  = '{L, L, 32'h0,         L, L, H, L,   H, 32'h3,         L, L, L, L, 3'd2, 16'd5, H, L};
        tbl[10] = '{L, L, 32'h0,         L, L, H, L,   H, 32'h4,         L, L, L, L, 3'd1, 16'd5, H, L};
        tbl[11] = '{L, L, 32'h0,         L, L, H, L,   L, 32'h0,         L, L, L, L, 3'd0, 16'd5, H, L};
        tbl[12] = '{L, H, 32'h8000_0000, H, H, L, L,   H, 32'h8000_0000, H, H, L, H, 3'd1, 16'd6, H, H};
        tbl[13] = '{L, L, 32'h0,         L, L, L, H,   H, 32'h8000_0000, H, H, L, H, 3'd1, 16'd6, H, L};
        tbl[14] = '{L, L, 32'h0,         L, L, H, L,   L, 32'h0,         L, L, L, L, 3'd0, 16'd6, H, L};
        tbl[15] = '{L, H, 32'h0,         L, L, L, L,   H, 32'h0,         L, L, H, L, 3'd1, 16'd7, H, L};
        tbl[16] = '{L, L, 32'h0,         L, L, H, L,   L, 32'h0,         L, L, L, L, 3'd0, 16'd7, H, L};

        rst = 1'b1; in_valid = 1'b0; in_ans = '0; in_cout = 1'b0; in_v = 1'b0;
        out_ready = 1'b0; clr_sticky = 1'b0;
        @(negedge clk);

        // Table-driven vectors with hand-computed expectations.
        for (int i = 0; i < 17; i++) begin
            cycle(tbl[i].rst, tbl[i].vld, tbl[i].ans, tbl[i].cout, tbl[i].v, tbl[i].ordy, tbl[i].clr);
            chk($sformatf("tbl%0d_valid", i),  32'(out_valid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_ans", i),    out_ans,        tbl[i].e_ans);
            chk($sformatf("tbl%0d_cout", i),   32'(out_cout),  32'(tbl[i].e_cout));
            chk($sformatf("tbl%0d_v", i),      32'(out_v),     32'(tbl[i].e_v));
            chk($sformatf("tbl%0d_zero", i),   32'(out_zero),  32'(tbl[i].e_zero));
            chk($sformatf("tbl%0d_neg", i),    32'(out_neg),   32'(tbl[i].e_neg));
            chk($sformatf("tbl%0d_level", i),  32'(level),     32'(tbl[i].e_level));
            chk($sformatf("tbl%0d_count", i),  32'(count),     32'(tbl[i].e_count));
            chk($sformatf("tbl%0d_rdy", i),    32'(in_ready),  32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_sticky", i), 32'(sticky_v),  32'(tbl[i].e_sticky));
        end

        // Wrap with simultaneous push/pop at level 2; final push sets v together with clear.
        cycle(H, L, 32'h0, L, L, L, L);
        cycle(L, H, 32'd10, L, L, L, L);
        cycle(L, H, 32'd11, L, L, L, L);
        for (int k = 0; k < 6; k++) begin
            cycle(L, H, 32'(12 + k), L, (k == 5), H, (k == 5));
            chk("wrap_level", 32'(level), 32'd2);
        end
        chk("wrap_head", out_ans, 32'd16);
        chk("wrap_sticky_set_wins", 32'(sticky_v), 32'd1);
        cycle(L, L, 32'h0, L, L, H, L);
        chk("wrap_next", out_ans, 32'd17);

        // Reset discards buffered entries and beats a simultaneous push, pop and clear.
        cycle(L, H, 32'h1, L, L, L, L);
        cycle(L, H, 32'h2, L, L, L, L);
        chk("pre_rst_level", 32'(level), 32'd3);
        cycle(H, H, 32'h7, L, H, H, H);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sticky", 32'(sticky_v), 32'd0);
        cycle(L, H, 32'h33, L, L, L, L);
        chk("first_push_after_rst", out_ans, 32'h33);

        // Counter saturation on the 4-bit instance.
        cycle(H, L, 32'h0, L, L, L, L);
        for (int k = 0; k < 17; k++) begin
            cycle(L, H, $urandom, L, L, H, L);
        end
        chk("small_count_sat", 32'(s_count), 32'hF);
        chk("main_count_17", 32'(count), 32'd17);
        cycle(L, H, 32'h1, L, L, H, L);
        chk("small_count_hold", 32'(s_count), 32'hF);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            logic [31:0] a;
            int          sel;
            sel = $urandom_range(0, 7);
            a   = (sel == 0) ? 32'h0 : (sel == 1) ? 32'h8000_0000 : $urandom;
            cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), a,
                  1'($urandom), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/addsub_result_stage.md
ADDSUB_RESULT_STAGE -- requirements
Module: addsub_result_stage

Interface
REQ-001 Parameter: DEPTH, 4, number of result-buffer entries (power of two, >=2).
REQ-002 Parameter: CNT_W, 16, width of accepted-result counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_valid  input  1  adder result (in_ans/in_cout/in_v) valid this cycle.
REQ-006 in_ready  output  1  stage can accept a result this cycle.
REQ-007 in_ans  input  32  sum/difference from the 32-bit add/sub stage.
REQ-008 in_cout  input  1  carry-out from the add/sub stage.
REQ-009 in_v  input  1  signed-overflow flag from the add/sub stage.
REQ-010 clr_sticky  input  1  clear request for sticky_v.
REQ-011 out_valid  output  1  head entry present.
REQ-012 out_ready  input  1  consumer takes head entry this cycle.
REQ-013 out_ans  output  32  head entry result.
REQ-014 out_cout  output  1  head entry carry.
REQ-015 out_v  output  1  head entry overflow.
REQ-016 out_zero  output  1  head entry result equals 32'h0.
REQ-017 out_neg  output  1  head entry result bit 31.
REQ-018 sticky_v  output  1  an overflowing result has been accepted since last clear/reset.
REQ-019 level  output  $clog2(DEPTH)+1  current number of stored entries.
REQ-020 count  output  CNT_W  number of results accepted since reset.

Function
REQ-021 Push occurs when in_valid && in_ready at a rising edge; pop occurs when out_valid && out_ready.
REQ-022 in_ready SHALL equal (level != DEPTH); no combinational dependence on out_ready (no push-when-full even if popping).
REQ-023 out_valid SHALL equal (level != 0); latency from push into empty buffer to out_valid high is exactly 1 cycle.
REQ-024 Entries SHALL leave in push order (FIFO); each entry stores {ans, cout, v}; out_zero/out_neg derived from stored ans.
REQ-025 When level == 0, out_ans, out_cout, out_v, out_zero, out_neg SHALL drive 0.
REQ-026 Simultaneous push and pop with 0 < level < DEPTH: level unchanged, read/write pointers both advance.
REQ-027 Push with level == DEPTH cannot occur (in_ready low); pop with level == 0 is ignored.
REQ-028 Read/write pointers wrap modulo DEPTH; full/empty decided from level, not pointer equality.
REQ-029 count SHALL increment by 1 on each push and saturate at all-ones (no wrap).
REQ-030 sticky_v SHALL set on a push whose in_v is 1; clear on clr_sticky; if both in same cycle, set wins (sticky_v = 1).
REQ-031 Stored data, counters, and flags SHALL hold when no push/pop/clear occurs; input X on in_ans when in_valid is low SHALL not affect state.

Reset
REQ-032 While rst is high at a rising edge: level = 0, pointers = 0, count = 0, sticky_v = 0, out_valid = 0, in_ready = 1, all out_* data = 0.
REQ-033 rst SHALL override simultaneous push, pop, and clr_sticky; buffered entries mid-stream are discarded.
REQ-034 First push accepted on the first rising edge after rst deasserts.

Verification
REQ-035 Reset then push 32'h0000_0005 (cout 0, v 0) with out_ready=0 -> next cycle out_valid=1, out_ans=5, level=1, count=1, out_zero=0.
REQ-036 Push four results 1,2,3,4 with out_ready=0 -> level=4, in_ready=0; fifth in_valid ignored; then out_ready=1 four cycles -> outputs 1,2,3,4 in order, level=0, out_ans=0.
REQ-037 Push 32'h8000_0000 with cout=1, v=1 -> out_neg=1, out_cout=1, out_v=1, sticky_v=1; pulse clr_sticky alone -> sticky_v=0.
REQ-038 level=2, assert in_valid and out_ready together for 6 cycles -> level stays 2, pointers wrap, order preserved; same-cycle v=1 push and clr_sticky -> sticky_v=1.
REQ-039 Push 32'h0 -> out_zero=1; assert rst with level=3 and in_valid high -> next cycle level=0, count=0, in_ready=1, out_valid=0.
REQ-040 Drive count to all-ones via forced/short CNT_W=4 instance and 17 pushes with out_ready=1 -> count holds 4'hF.
